// File: rtl/dma_mbus_arb.sv
// dma_mbus_arb: round-robin owner arbitration of the memory-bus master port across DMA channels, with a burst cap.
module dma_mbus_arb #(
  parameter int NCHAN     = 4,
  parameter int MAX_BURST = 8,
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCHAN-1:0]         ch_req,
  input  logic [NCHAN-1:0]         ch_we,
  input  logic [NCHAN-1:0]         ch_last,
  input  logic [NCHAN*ADDR_W-1:0]  ch_addr,
  input  logic [NCHAN*DATA_W-1:0]  ch_wdata,
  output logic [NCHAN-1:0]         ch_gnt,
  output logic [NCHAN-1:0]         ch_ack,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mbus_re,
  output logic                     mbus_we,
  output logic [ADDR_W-1:0]        mbus_addr,
  output logic [DATA_W-1:0]        mbus_wdata,
  input  logic [DATA_W-1:0]        mbus_rdata,
  input  logic                     mbus_ready
);
  localparam int IW = $clog2(NCHAN);
  localparam logic [7:0] MB = 8'(MAX_BURST);
  typedef enum logic {IDLE, OWN} state_t;
  state_t           state_q;
  logic [IW-1:0]    own_q, rr_q, pick, c;
  logic [NCHAN-1:0] gnt_q;
  logic [7:0]       cnt_q;
  logic             own, req_o, done, rel;
  // Scan from rr_q+NCHAN down to rr_q+1 so the nearest requester after rr_q wins.
  always_comb begin
    pick = rr_q;
    c = '0;
    for (int k = NCHAN; k >= 1; k--) begin
      c = IW'((int'(rr_q) + k) % NCHAN);
      if (ch_req[c]) pick = c;
    end
  end
  assign own      = state_q == OWN;
  assign req_o    = own & ch_req[own_q];
  assign mbus_re  = req_o & ~ch_we[own_q];
  assign mbus_we  = req_o & ch_we[own_q];
  assign done     = req_o & mbus_ready & ~rst;
  assign rel      = own & (~ch_req[own_q] | (done & (ch_last[own_q] | (cnt_q + 8'd1 == MB))));
  assign ch_gnt   = gnt_q;
  assign ch_ack   = done ? gnt_q : '0;
  assign ch_rdata = mbus_rdata;
  always_comb begin
    mbus_addr  = '0;
    mbus_wdata = '0;
    for (int i = 0; i < NCHAN; i++)
      if (own && own_q == IW'(i)) begin
        mbus_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        mbus_wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      rr_q    <= IW'(NCHAN - 1);
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (|ch_req) begin
        state_q <= OWN;
        own_q   <= pick;
        gnt_q   <= NCHAN'(1) << pick;
        cnt_q   <= '0;
      end
    end else if (rel) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= own_q;
    end else if (done) begin
      cnt_q   <= cnt_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_dma_mbus_arb.sv
// tb_dma_mbus_arb: vector table, directed corner sequences and random traffic against a behavioural arbiter model.
module tb_dma_mbus_arb;
  localparam int N = 4, MB = 8, AW = 48, DW = 64;
  logic clk = 0, rst = 1, ready = 0;
  logic [N-1:0] req = '0, we = '0, last = '0;
  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_wdata [N];
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_wdata;
  logic [N-1:0] gnt, ack;
  logic [DW-1:0] rdata, mrdata = '0, mwdata;
  logic [AW-1:0] maddr;
  logic re, wr;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign ch_addr[g*AW +: AW]  = a_addr[g];
    assign ch_wdata[g*DW +: DW] = a_wdata[g];
  end
  dma_mbus_arb #(.NCHAN(N), .MAX_BURST(MB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ch_req(req), .ch_we(we), .ch_last(last),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_gnt(gnt), .ch_ack(ack), .ch_rdata(rdata),
    .mbus_re(re), .mbus_we(wr), .mbus_addr(maddr), .mbus_wdata(mwdata),
    .mbus_rdata(mrdata), .mbus_ready(ready)
  );
  int checks = 0, failures = 0;
  int m_st = 0, m_own = 0, m_rr = N - 1, m_cnt = 0;
  logic [N-1:0] s_gnt, s_ack;
  logic s_re, s_we;
  logic [AW-1:0] s_addr;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cycle(input string nm);
    logic [N-1:0] eg, ea;
    logic ro;
    @(negedge clk); #1;
    s_gnt = gnt; s_ack = ack; s_re = re; s_we = wr; s_addr = maddr;
    eg = m_st == 1 ? 4'b0001 << m_own : 4'b0000;
    ro = m_st == 1 && req[m_own];
    ea = (ro && ready && !rst) ? eg : 4'b0000;
    chk({nm, " gnt"}, 64'(s_gnt), 64'(eg));
    chk({nm, " ack"}, 64'(s_ack), 64'(ea));
    chk({nm, " re"}, 64'(s_re), 64'(ro && !we[m_own]));
    chk({nm, " we"}, 64'(s_we), 64'(ro && we[m_own]));
    chk({nm, " addr"}, 64'(s_addr), m_st == 1 ? 64'(a_addr[m_own]) : 64'd0);
    if (m_st == 1) chk({nm, " wdata"}, mwdata, a_wdata[m_own]);
    if (ea != 0) chk({nm, " rdata"}, rdata, mrdata);
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_rr = N - 1; m_cnt = 0;
    end else if (m_st == 0) begin
      for (int k = 1; k <= N && m_st == 0; k++)
        if (req[(m_rr + k) % N]) begin m_own = (m_rr + k) % N; m_st = 1; m_cnt = 0; end
    end else if (!req[m_own]) begin
      m_st = 0; m_rr = m_own;
    end else if (ready) begin
      m_cnt++;
      if (last[m_own] || m_cnt == MB) begin m_st = 0; m_rr = m_own; end
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1; req = '0; cycle("reset"); rst = 0;
  endtask
  typedef struct {
    logic rst; logic [3:0] req, we, last; logic rdy;
    logic [3:0] gnt, ack; logic re, wr;
  } vec_t;
  vec_t tv [16];
  int rem [N];
  bit act [N];
  int n;
  logic [AW-1:0] a0;
  initial begin
    for (int i = 0; i < N; i++) begin
      a_addr[i] = AW'(48'h1000 * (i + 1)); a_wdata[i] = 64'hA000 + DW'(i); rem[i] = 0; act[i] = 0;
    end
    @(posedge clk); #1;
    cycle("init");
    rst = 0;
    // single ch2 read, then all four channels with single-beat bursts from a fresh reset
    tv[0]  = '{0, 4'b0100, 4'b0000, 4'b0100, 1, 4'b0000, 4'b0000, 0, 0};
    tv[1]  = '{0, 4'b0100, 4'b0000, 4'b0100, 1, 4'b0100, 4'b0100, 1, 0};
    tv[2]  = '{0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0};
    tv[3]  = '{1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0};
    tv[4]  = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0};
    tv[5]  = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0001, 4'b0001, 1, 0};
    tv[6]  = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0};
    tv[7]  = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0010, 4'b0010, 1, 0};
    tv[8]  = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0};
    tv[9]  = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0100, 4'b0100, 1, 0};
    tv[10] = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0};
    tv[11] = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b1000, 4'b1000, 1, 0};
    tv[12] = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0};
    tv[13] = '{0, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0001, 4'b0001, 1, 0};
    tv[14] = '{0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0};
    tv[15] = '{0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0};
    for (int v = 0; v < 16; v++) begin
      rst = tv[v].rst; req = tv[v].req; we = tv[v].we; last = tv[v].last; ready = tv[v].rdy;
      mrdata = 64'hD00D_0000 + DW'(v);
      cycle("vec");
      chk($sformatf("vec%0d gnt", v), 64'(s_gnt), 64'(tv[v].gnt));
      chk($sformatf("vec%0d ack", v), 64'(s_ack), 64'(tv[v].ack));
      chk($sformatf("vec%0d re", v), 64'(s_re), 64'(tv[v].re));
      chk($sformatf("vec%0d we", v), 64'(s_we), 64'(tv[v].wr));
    end
    // burst cap: ch1 never signals last, ch2 waiting
    do_reset();
    req = 4'b0110; we = 4'b0010; last = '0; ready = 1;
    cycle("t3 idle");
    n = 0;
    repeat (8) begin cycle("t3 beat"); if (s_ack[1]) n++; end
    chk("t3 acks", 64'(n), 64'd8);
    cycle("t3 turn"); chk("t3 turn gnt", 64'(s_gnt), 64'd0);
    cycle("t3 next"); chk("t3 ch2 gnt", 64'(s_gnt), 64'b0100);
    // stall: ready low for five cycles during ch0 read
    do_reset();
    req = 4'b0001; we = '0; last = 4'b0001; ready = 0;
    cycle("t4 idle"); cycle("t4 s0"); a0 = s_addr; n = 0;
    repeat (4) begin
      cycle("t4 stall");
      chk("t4 addr stable", 64'(s_addr), 64'(a0));
      chk("t4 re held", 64'(s_re), 64'd1);
      if (s_ack != 0) n++;
    end
    chk("t4 no ack", 64'(n), 64'd0);
    ready = 1; cycle("t4 go"); chk("t4 ack", 64'(s_ack), 64'b0001);
    // reset in the middle of a ch3 burst
    do_reset();
    req = 4'b1000; we = 4'b1000; last = '0; ready = 1;
    cycle("t5 idle"); cycle("t5 b1"); cycle("t5 b2");
    chk("t5 owner", 64'(s_gnt), 64'b1000);
    rst = 1; cycle("t5 rst"); chk("t5 rst ack", 64'(s_ack), 64'd0);
    rst = 0; req = 4'b1001;
    cycle("t5 after"); chk("t5 gnt cleared", 64'(s_gnt), 64'd0); chk("t5 strobes", 64'({s_re, s_we}), 64'd0);
    cycle("t5 win"); chk("t5 ch0 wins", 64'(s_gnt), 64'b0001);
    // owner abandons on its third beat
    do_reset();
    req = 4'b0010; we = 4'b0010; last = '0; ready = 1;
    cycle("t6 idle"); req = 4'b0111;
    cycle("t6 b1"); cycle("t6 b2");
    req = 4'b0101; cycle("t6 drop"); chk("t6 drop ack", 64'(s_ack), 64'd0);
    cycle("t6 turn"); cycle("t6 next"); chk("t6 ch2 first", 64'(s_gnt), 64'b0100);
    // random traffic from modelled channel engines
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      rst = $urandom_range(0, 399) == 0;
      ready = $urandom_range(0, 3) != 0;
      mrdata = {$urandom, $urandom};
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i] = 1; rem[i] = $urandom_range(1, 12); we[i] = 1'($urandom);
          a_addr[i] = AW'({$urandom, $urandom}); a_wdata[i] = {$urandom, $urandom};
        end else if (act[i] && $urandom_range(0, 63) == 0) act[i] = 0;
        req[i] = act[i];
        last[i] = act[i] && rem[i] == 1;
      end
      cycle("rnd");
      for (int i = 0; i < N; i++)
        if (s_ack[i]) begin
          rem[i]--;
          if (rem[i] == 0) act[i] = 0;
          else begin a_addr[i] = AW'({$urandom, $urandom}); a_wdata[i] = {$urandom, $urandom}; end
        end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
